// File: rtl/rv_decode_regfile_pipe.sv
`default_nettype none
// ============================================================================
// Module   : rv_decode_regfile_pipe
// Purpose  : RV32I decode stage fused with a register file, a write-back
//            bypass and a RAW scoreboard. Decoded bundles are held in a
//            one-deep output register with a valid/ready handshake.
// Ports    : clk, reset (async, active-low)
//            in_valid/in_ready/komut        - instruction input handshake
//            out_valid/out_ready            - decoded bundle handshake
//            opcode, aluop, rd, rs1_data, rs2_data, imm, hata - bundle
//            we, waddr, wdata               - write-back port
// Revision : 1.0 - initial release
// ============================================================================
module rv_decode_regfile_pipe #(
   parameter int XLEN          = 32,
   parameter int NREGS         = 32,
   parameter bit SCOREBOARD_EN = 1'b1,
   localparam int AW           = $clog2(NREGS)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     komut,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [6:0]      opcode,
   output logic [3:0]      aluop,
   output logic [AW-1:0]   rd,
   output logic [XLEN-1:0] rs1_data,
   output logic [XLEN-1:0] rs2_data,
   output logic [XLEN-1:0] imm,
   output logic            hata,
   input  logic            we,
   input  logic [AW-1:0]   waddr,
   input  logic [XLEN-1:0] wdata
);

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IALU   = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;

   // ------------------------------------------------------------------
   // Decode
   // ------------------------------------------------------------------
   logic [4:0]      rs1_idx, rs2_idx, rd_idx;
   logic [AW-1:0]   rs1_a, rs2_a, rd_a;
   logic [3:0]      aluop_d;
   logic [31:0]     imm32;
   logic [XLEN-1:0] imm_d;
   logic            illegal, oor, hata_d;
   logic            use_rs1, use_rs2, wr_rd, writes_rd;
   logic            hazard, fire;

   assign rs1_idx = komut[19:15];
   assign rs2_idx = komut[24:20];
   assign rd_idx  = komut[11:7];
   assign rs1_a   = rs1_idx[AW-1:0];
   assign rs2_a   = rs2_idx[AW-1:0];
   assign rd_a    = rd_idx[AW-1:0];

   always_comb begin
      aluop_d = 4'b0000;
      imm32   = 32'd0;
      illegal = 1'b0;
      use_rs1 = 1'b0;
      use_rs2 = 1'b0;
      wr_rd   = 1'b0;
      case (komut[6:0])
         OP_R: begin
            aluop_d = {komut[30], komut[14:12]};
            use_rs1 = 1'b1;
            use_rs2 = 1'b1;
            wr_rd   = 1'b1;
         end
         OP_IALU: begin
            // funct7[5] only distinguishes SRLI/SRAI; elsewhere it is immediate
            aluop_d = {(komut[14:12] == 3'b101) ? komut[30] : 1'b0, komut[14:12]};
            imm32   = {{20{komut[31]}}, komut[31:20]};
            use_rs1 = 1'b1;
            wr_rd   = 1'b1;
         end
         OP_LOAD, OP_JALR: begin
            imm32   = {{20{komut[31]}}, komut[31:20]};
            use_rs1 = 1'b1;
            wr_rd   = 1'b1;
         end
         OP_STORE: begin
            imm32   = {{20{komut[31]}}, komut[31:25], komut[11:7]};
            use_rs1 = 1'b1;
            use_rs2 = 1'b1;
         end
         OP_BRANCH: begin
            aluop_d = {1'b0, komut[14:12]};
            imm32   = {{19{komut[31]}}, komut[31], komut[7], komut[30:25],
                       komut[11:8], 1'b0};
            use_rs1 = 1'b1;
            use_rs2 = 1'b1;
         end
         OP_LUI, OP_AUIPC: begin
            imm32   = {komut[31:12], 12'd0};
            wr_rd   = 1'b1;
         end
         OP_JAL: begin
            imm32   = {{11{komut[31]}}, komut[31], komut[19:12], komut[20],
                       komut[30:21], 1'b0};
            wr_rd   = 1'b1;
         end
         default: illegal = 1'b1;
      endcase
   end

   // Register indices beyond the implemented file are only possible for NREGS<32
   if (NREGS < 32) begin : g_range
      localparam logic [5:0] NLIM = 6'(NREGS);
      assign oor = (use_rs1 && ({1'b0, rs1_idx} >= NLIM)) ||
                   (use_rs2 && ({1'b0, rs2_idx} >= NLIM)) ||
                   (wr_rd   && ({1'b0, rd_idx}  >= NLIM));
   end else begin : g_full_range
      assign oor = 1'b0;
   end

   assign hata_d    = illegal | oor;
   assign writes_rd = wr_rd && (rd_idx != 5'd0) && !hata_d;
   assign imm_d     = XLEN'($signed(imm32));

   // ------------------------------------------------------------------
   // Register file with write-back bypass
   // ------------------------------------------------------------------
   logic [XLEN-1:0] regs_q [NREGS];
   logic [XLEN-1:0] rs1_d, rs2_d;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      end else if (we && (waddr != '0)) begin
         regs_q[waddr] <= wdata;
      end
   end

   always_comb begin
      rs1_d = regs_q[rs1_a];
      rs2_d = regs_q[rs2_a];
      if (we && (waddr == rs1_a)) rs1_d = wdata;
      if (we && (waddr == rs2_a)) rs2_d = wdata;
      if (rs1_a == '0) rs1_d = '0;
      if (rs2_a == '0) rs2_d = '0;
   end

   // ------------------------------------------------------------------
   // Scoreboard: a same-cycle write-back to a pending source releases it
   // ------------------------------------------------------------------
   if (SCOREBOARD_EN) begin : g_sb
      logic [NREGS-1:0] pending_q, pending_d;

      always_comb begin
         pending_d = pending_q;
         if (we) pending_d[waddr] = 1'b0;
         // issue-side set is applied last so it wins over a same-cycle clear
         if (fire && writes_rd) pending_d[rd_a] = 1'b1;
      end

      always_ff @(posedge clk or negedge reset) begin
         if (!reset) pending_q <= '0;
         else        pending_q <= pending_d;
      end

      assign hazard = (use_rs1 && (rs1_a != '0) && pending_q[rs1_a] &&
                       !(we && (waddr == rs1_a))) ||
                      (use_rs2 && (rs2_a != '0) && pending_q[rs2_a] &&
                       !(we && (waddr == rs2_a)));
   end else begin : g_no_sb
      assign hazard = 1'b0;
   end

   // ------------------------------------------------------------------
   // Output register
   // ------------------------------------------------------------------
   logic            out_valid_q, hata_q;
   logic [6:0]      opcode_q;
   logic [3:0]      aluop_q;
   logic [AW-1:0]   rd_q;
   logic [XLEN-1:0] rs1_q, rs2_q, imm_q;

   assign in_ready = (!out_valid_q || out_ready) && !hazard;
   assign fire     = in_valid && in_ready;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_valid_q <= 1'b0;
         opcode_q    <= '0;
         aluop_q     <= '0;
         rd_q        <= '0;
         rs1_q       <= '0;
         rs2_q       <= '0;
         imm_q       <= '0;
         hata_q      <= 1'b0;
      end else if (fire) begin
         out_valid_q <= 1'b1;
         opcode_q    <= komut[6:0];
         aluop_q     <= hata_d ? 4'b0000 : aluop_d;
         rd_q        <= rd_a;
         rs1_q       <= rs1_d;
         rs2_q       <= rs2_d;
         imm_q       <= hata_d ? '0 : imm_d;
         hata_q      <= hata_d;
      end else if (out_ready) begin
         out_valid_q <= 1'b0;
      end
   end

   assign out_valid = out_valid_q;
   assign opcode    = opcode_q;
   assign aluop     = aluop_q;
   assign rd        = rd_q;
   assign rs1_data  = rs1_q;
   assign rs2_data  = rs2_q;
   assign imm       = imm_q;
   assign hata      = hata_q;

endmodule
`default_nettype wire

// File: tb/tb_rv_decode_regfile_pipe.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_rv_decode_regfile_pipe
// Purpose  : Self-checking bench for rv_decode_regfile_pipe. Expected bundles
//            are queued when an instruction is driven and compared when the
//            DUT presents them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rv_decode_regfile_pipe;

   typedef struct {
      logic [6:0]  op;
      logic [3:0]  alu;
      logic [4:0]  rd;
      logic [31:0] r1;
      logic [31:0] r2;
      logic [31:0] imm;
      logic        h;
      bit          c1;
      bit          c2;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] komut = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [6:0]  opcode;
   logic [3:0]  aluop;
   logic [4:0]  rd;
   logic [31:0] rs1_data, rs2_data, imm;
   logic        hata;
   logic        we = 1'b0;
   logic [4:0]  waddr = '0;
   logic [31:0] wdata = '0;

   exp_t q[$];
   int   n_run = 0;
   int   n_fail = 0;

   rv_decode_regfile_pipe #(.XLEN(32), .NREGS(32), .SCOREBOARD_EN(1'b1)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .komut(komut), .out_valid(out_valid), .out_ready(out_ready),
      .opcode(opcode), .aluop(aluop), .rd(rd), .rs1_data(rs1_data),
      .rs2_data(rs2_data), .imm(imm), .hata(hata),
      .we(we), .waddr(waddr), .wdata(wdata)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   function automatic exp_t mk(input logic [6:0] op, input logic [3:0] alu,
                               input logic [4:0] rdx, input logic [31:0] r1,
                               input logic [31:0] r2, input logic [31:0] im,
                               input logic h, input bit c1, input bit c2);
      exp_t e;
      e.op = op; e.alu = alu; e.rd = rdx; e.r1 = r1; e.r2 = r2;
      e.imm = im; e.h = h; e.c1 = c1; e.c2 = c2;
      return e;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr_reg(input logic [4:0] a, input logic [31:0] d);
      we = 1'b1; waddr = a; wdata = d;
      tick();
      we = 1'b0;
   endtask

   // Queue the expectation, hold the instruction until accepted
   task automatic send(input logic [31:0] k, input exp_t e);
      int n = 0;
      q.push_back(e);
      komut = k;
      in_valid = 1'b1;
      #1;
      while (!in_ready && n < 20) begin
         tick();
         n++;
      end
      n_run++;
      if (in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL send_accept komut=%h in_ready=%b required 1", k, in_ready);
      end
      tick();
      in_valid = 1'b0;
   endtask

   // Pop the oldest expectation once the DUT holds a bundle
   task automatic expect_out(input string name);
      int   n = 0;
      exp_t e;
      while (!out_valid && n < 20) begin
         tick();
         n++;
      end
      n_run++;
      if (out_valid !== 1'b1 || q.size() == 0) begin
         n_fail++;
         $display("FAIL %s out_valid=%b queued=%0d required valid with entry",
                  name, out_valid, q.size());
         return;
      end
      e = q.pop_front();
      n_run++;
      if (opcode !== e.op) begin
         n_fail++; $display("FAIL %s opcode got=%h exp=%h", name, opcode, e.op);
      end
      n_run++;
      if (aluop !== e.alu) begin
         n_fail++; $display("FAIL %s aluop got=%b exp=%b", name, aluop, e.alu);
      end
      n_run++;
      if (rd !== e.rd) begin
         n_fail++; $display("FAIL %s rd got=%0d exp=%0d", name, rd, e.rd);
      end
      n_run++;
      if (imm !== e.imm) begin
         n_fail++; $display("FAIL %s imm got=%h exp=%h", name, imm, e.imm);
      end
      n_run++;
      if (hata !== e.h) begin
         n_fail++; $display("FAIL %s hata got=%b exp=%b", name, hata, e.h);
      end
      if (e.c1) begin
         n_run++;
         if (rs1_data !== e.r1) begin
            n_fail++; $display("FAIL %s rs1_data got=%h exp=%h", name, rs1_data, e.r1);
         end
      end
      if (e.c2) begin
         n_run++;
         if (rs2_data !== e.r2) begin
            n_fail++; $display("FAIL %s rs2_data got=%h exp=%h", name, rs2_data, e.r2);
         end
      end
   endtask

   task automatic test_reset();
      #2;
      n_run++;
      if ({out_valid, opcode, aluop, rd, hata} !== '0 ||
          {rs1_data, rs2_data, imm} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs valid=%b op=%h alu=%h rd=%0d imm=%h required all 0",
                  out_valid, opcode, aluop, rd, imm);
      end
      n_run++;
      if (in_ready !== 1'b1) begin
         n_fail++; $display("FAIL reset_in_ready got=%b exp=1", in_ready);
      end
      #10 reset = 1'b1;
      tick();
   endtask

   task automatic test_regfile_read();
      wr_reg(5'd5, 32'h1234);
      // add x6,x5,x0
      send(32'h00028333, mk(7'h33, 4'h0, 5'd6, 32'h1234, 32'h0, 32'h0, 1'b0, 1, 1));
      expect_out("add_x6_x5_x0");
   endtask

   task automatic test_raw_stall();
      // addi x3,x0,-1
      send(32'hFFF00193, mk(7'h13, 4'h0, 5'd3, 32'h0, 32'h0, 32'hFFFFFFFF, 1'b0, 1, 0));
      expect_out("addi_x3");
      komut = 32'h00318233;   // add x4,x3,x3
      in_valid = 1'b1;
      #1;
      n_run++;
      if (in_ready !== 1'b0) begin
         n_fail++; $display("FAIL raw_stall in_ready got=%b exp=0", in_ready);
      end
      tick();
      n_run++;
      if (in_ready !== 1'b0) begin
         n_fail++; $display("FAIL raw_stall_hold in_ready got=%b exp=0", in_ready);
      end
      we = 1'b1; waddr = 5'd3; wdata = 32'hFFFFFFFF;
      #1;
      n_run++;
      if (in_ready !== 1'b1) begin
         n_fail++; $display("FAIL raw_release in_ready got=%b exp=1", in_ready);
      end
      q.push_back(mk(7'h33, 4'h0, 5'd4, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 1'b0, 1, 1));
      tick();
      in_valid = 1'b0;
      we = 1'b0;
      expect_out("add_x4_bypass");
      komut = 32'h00318233;
      in_valid = 1'b1;
      #1;
      n_run++;
      if (in_ready !== 1'b1) begin
         n_fail++; $display("FAIL pending3_cleared in_ready got=%b exp=1", in_ready);
      end
      in_valid = 1'b0;
      send(32'h00318233, mk(7'h33, 4'h0, 5'd4, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 1'b0, 1, 1));
      expect_out("add_x4_regfile");
   endtask

   task automatic test_backpressure();
      tick();
      out_ready = 1'b0;
      // addi x7,x0,5
      send(32'h00500393, mk(7'h13, 4'h0, 5'd7, 32'h0, 32'h0, 32'h5, 1'b0, 1, 0));
      komut = 32'h12345437;   // lui x8,0x12345
      in_valid = 1'b1;
      #1;
      n_run++;
      if (in_ready !== 1'b0) begin
         n_fail++; $display("FAIL backpressure in_ready got=%b exp=0", in_ready);
      end
      tick();
      tick();
      n_run++;
      if (out_valid !== 1'b1 || imm !== 32'h5 || rd !== 5'd7 || opcode !== 7'h13) begin
         n_fail++;
         $display("FAIL held_stable valid=%b imm=%h rd=%0d op=%h exp 1/00000005/7/13",
                  out_valid, imm, rd, opcode);
      end
      out_ready = 1'b1;
      #1;
      n_run++;
      if (in_ready !== 1'b1) begin
         n_fail++; $display("FAIL drain_in_ready got=%b exp=1", in_ready);
      end
      expect_out("addi_x7_held");
      q.push_back(mk(7'h37, 4'h0, 5'd8, 32'h0, 32'h0, 32'h12345000, 1'b0, 0, 0));
      tick();
      in_valid = 1'b0;
      expect_out("lui_x8");
      tick();
      n_run++;
      if (out_valid !== 1'b0) begin
         n_fail++; $display("FAIL out_valid_drop got=%b exp=0", out_valid);
      end
   endtask

   task automatic test_illegal_x0();
      send(32'hFFFFFFFF, mk(7'h7F, 4'h0, 5'd31, 32'h0, 32'h0, 32'h0, 1'b1, 0, 0));
      expect_out("illegal");
      komut = 32'h01FF84B3;   // add x9,x31,x31
      in_valid = 1'b1;
      #1;
      n_run++;
      if (in_ready !== 1'b1) begin
         n_fail++; $display("FAIL illegal_no_pending in_ready got=%b exp=1", in_ready);
      end
      in_valid = 1'b0;
      wr_reg(5'd0, 32'h7);
      we = 1'b1; waddr = 5'd0; wdata = 32'h7;
      // add x10,x0,x0 with a same-cycle write to x0
      send(32'h00000533, mk(7'h33, 4'h0, 5'd10, 32'h0, 32'h0, 32'h0, 1'b0, 1, 1));
      we = 1'b0;
      expect_out("read_x0");
   endtask

   task automatic test_store_branch_shift();
      wr_reg(5'd1, 32'h11);
      wr_reg(5'd2, 32'h22);
      // sw x2,-4(x1)
      send(32'hFE20AE23, mk(7'h23, 4'h0, 5'd28, 32'h11, 32'h22, 32'hFFFFFFFC, 1'b0, 1, 1));
      expect_out("sw");
      komut = 32'h000E05B3;   // add x11,x28,x0
      in_valid = 1'b1;
      #1;
      n_run++;
      if (in_ready !== 1'b1) begin
         n_fail++; $display("FAIL store_no_pending in_ready got=%b exp=1", in_ready);
      end
      in_valid = 1'b0;
      // bne x1,x2,+8
      send(32'h00209463, mk(7'h63, 4'h1, 5'd8, 32'h11, 32'h22, 32'h8, 1'b0, 1, 1));
      expect_out("bne");
      // srai x1,x1,3
      send(32'h4030D093, mk(7'h13, 4'hD, 5'd1, 32'h11, 32'h0, 32'h403, 1'b0, 1, 0));
      expect_out("srai");
   endtask

   task automatic test_async_reset();
      tick();
      out_ready = 1'b0;
      // addi x13,x0,1
      send(32'h00100693, mk(7'h13, 4'h0, 5'd13, 32'h0, 32'h0, 32'h1, 1'b0, 1, 0));
      #3 reset = 1'b0;
      #1;
      n_run++;
      if ({out_valid, opcode, aluop, rd, hata} !== '0 ||
          {rs1_data, rs2_data, imm} !== '0) begin
         n_fail++;
         $display("FAIL async_reset valid=%b op=%h rd=%0d imm=%h rs1=%h required all 0",
                  out_valid, opcode, rd, imm, rs1_data);
      end
      q.delete();
      #2 reset = 1'b1;
      out_ready = 1'b1;
      tick();
      komut = 32'h00D08733;   // add x14,x1,x13
      in_valid = 1'b1;
      #1;
      n_run++;
      if (in_ready !== 1'b1) begin
         n_fail++; $display("FAIL post_reset_no_stall in_ready got=%b exp=1", in_ready);
      end
      in_valid = 1'b0;
      send(32'h00D08733, mk(7'h33, 4'h0, 5'd14, 32'h0, 32'h0, 32'h0, 1'b0, 1, 1));
      expect_out("post_reset_add");
   endtask

   initial begin
      test_reset();
      test_regfile_read();
      test_raw_stall();
      test_backpressure();
      test_illegal_x0();
      test_store_branch_shift();
      test_async_reset();
      n_run++;
      if (q.size() != 0) begin
         n_fail++; $display("FAIL scoreboard_drained left=%0d exp=0", q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/rv_decode_regfile_pipe.md
Name: rv_decode_regfile_pipe

Overview:
Parametrised RV32I decode stage fused with a register file, a write-back bypass and a scoreboard. Instructions enter through a valid/ready handshake. They are decoded and their operands read, and the result is held in a one-deep output register with its own valid/ready handshake. Issue stalls while a source register has an outstanding write. The block sits between fetch and the ALU/execute stage; the write-back port comes from the execute/memory stage.

Parameters:
XLEN, 32, datapath width of register contents, rs1_data, rs2_data and imm (at least 32; imm sign-extended to XLEN).
NREGS, 32, number of architectural registers (power of 2, at most 32); AW = clog2(NREGS).
SCOREBOARD_EN, 1, 1 enables the RAW-hazard stall; 0 never stalls on hazards.

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
in_valid  input  1  komut is valid
in_ready  output  1  block accepts komut this cycle
komut  input  32  instruction word
out_valid  output  1  decoded bundle valid
out_ready  input  1  downstream accepts bundle
opcode  output  7  komut[6:0] of held instruction
aluop  output  4  ALU operation code
rd  output  AW  destination register
rs1_data  output  XLEN  operand 1
rs2_data  output  XLEN  operand 2
imm  output  XLEN  sign-extended immediate
hata  output  1  illegal/unsupported instruction flag
we  input  1  write-back enable
waddr  input  AW  write-back register
wdata  input  XLEN  write-back data

Behaviour:
- Reset (reset=0, asynchronous): out_valid=0; opcode, aluop, rd, rs1_data, rs2_data, imm = 0; hata=0; all registers and the scoreboard cleared. Leaving reset needs no extra cycles. Reset mid-stall drops the held bundle.
- Issue: fire = in_valid & in_ready. in_ready = (~out_valid | out_ready) & ~hazard.
- Latency: 1 cycle. The bundle is registered on fire and out_valid=1 the next cycle. Outputs are stable while out_valid & ~out_ready.
- If out_ready and there is no fire, out_valid goes to 0.
- Register file:
  - x0 always reads 0; writes to x0 are ignored.
  - A write takes effect at the clock edge when we=1.
  - Read addresses are komut[19:15] and komut[24:20], truncated to AW bits. For NREGS<32, any source or rd index >= NREGS sets hata.
- Bypass: if we & waddr==rs (and rs!=0) in the fire cycle, the operand takes wdata.
- Decode and aluop:
  - R (0110011): aluop = {funct7[5], funct3}, imm = 0.
  - I-ALU (0010011): aluop = {funct3==101 ? funct7[5] : 0, funct3}, I-imm.
  - LOAD (0000011): aluop = 0000, I-imm.
  - STORE (0100011): aluop = 0000, S-imm.
  - BRANCH (1100011): aluop = {0, funct3}, B-imm.
  - LUI and AUIPC: aluop = 0000, U-imm.
  - JAL: aluop = 0000, J-imm.
  - JALR: aluop = 0000, I-imm.
  - Any other opcode: hata=1, aluop=0, imm=0. The bundle is still emitted.
- Writes-rd set: R, I-ALU, LOAD, LUI, AUIPC, JAL, JALR with rd != 0 and hata=0.
- Scoreboard (when SCOREBOARD_EN=1): one pending bit per register.
  - On fire of a writes-rd instruction, pending[rd] is set.
  - we clears pending[waddr].
  - If both set and clear hit the same register in one cycle, set wins.
- Hazard: hazard = used source register rs with pending[rs]=1 and not (we & waddr==rs).
  - Sources used: rs1 for all except LUI, AUIPC and JAL; rs2 for R, STORE and BRANCH only.
  - x0 is never a hazard.
  - A write-back in the same cycle releases the stall and supplies the value through the bypass.

Test Plan:
- Reset, then we=1, waddr=5, wdata=0x1234 for one cycle; then komut=add x6,x5,x0 -> next cycle out_valid=1, rs1_data=0x1234, rs2_data=0, aluop=0000, rd=6, opcode=0110011.
- Issue addi x3,x0,-1 followed by add x4,x3,x3 -> in_ready=0 on the second instruction. Then we=1, waddr=3, wdata=0xFFFFFFFF -> fire in that same cycle, rs1_data=rs2_data=0xFFFFFFFF, and pending[3] is cleared.
- Hold out_ready=0 with out_valid=1 and present a new komut -> in_ready=0 and the outputs stay unchanged. Raise out_ready -> the new bundle appears the following cycle.
- komut=0xFFFFFFFF -> hata=1, aluop=0, imm=0, and the scoreboard is unchanged. Also write wdata=7 to x0, then read x0 -> 0.
- sw x2,-4(x1) -> imm=0xFFFFFFFC, aluop=0000, no scoreboard set. srai x1,x1,3 -> aluop=1101.
- Assert reset=0 asynchronously while out_valid=1 and pending bits are set -> all outputs are 0 immediately, and after release the previously pending registers do not stall.
